// File: rtl/display_cfg_pkg.sv
// display_cfg_pkg: shared config-word layout and FSM encoding for the display config serialiser
package display_cfg_pkg;
  localparam int CONFIG_LEN = 75;
  localparam int PULSE_COUNT_MSB = 74, PULSE_COUNT_LSB = 69;
  localparam int H_POL = 68;
  localparam int V_POL = 67;
  localparam int H_DISPLAY_MSB = 66, H_DISPLAY_LSB = 56;
  localparam int H_FRONT_MSB = 55, H_FRONT_LSB = 47;
  localparam int H_SYNC_MSB = 46, H_SYNC_LSB = 38;
  localparam int H_BACK_MSB = 37, H_BACK_LSB = 29;
  localparam int V_DISPLAY_MSB = 28, V_DISPLAY_LSB = 18;
  localparam int V_BOTTOM_MSB = 17, V_BOTTOM_LSB = 12;
  localparam int V_SYNC_MSB = 11, V_SYNC_LSB = 6;
  localparam int V_TOP_MSB = 5, V_TOP_LSB = 0;
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, TAIL, SETTLE, RUN} state_t;
endpackage

// File: rtl/display_cfg_tx.sv
// display_cfg_tx: shifts a timing word out on cfg_clk/cfg_data MSB first, then raises en
module display_cfg_tx
  import display_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CONFIG_LEN-1:0] cfg_word,
  input  logic                  start,
  input  logic                  stop,
  output logic                  cfg_clk,
  output logic                  cfg_data,
  output logic                  en,
  output logic                  busy,
  output logic                  done
);
  localparam int DW = $clog2(CLK_DIV > SETTLE_CYCLES ? CLK_DIV : SETTLE_CYCLES);
  localparam int BW = $clog2(CONFIG_LEN);
  localparam logic [DW-1:0] DIV_LD = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] SET_LD = DW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LD = BW'(CONFIG_LEN - 1);
  state_t state, state_n;
  logic [DW-1:0] div, div_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [CONFIG_LEN-1:0] sr, sr_n;
  logic tick;
  always_comb begin
    tick = div == '0;
    state_n = state;
    div_n = tick ? '0 : div - 1'b1;
    bit_n = bit_cnt;
    sr_n = sr;
    if (start && (state == IDLE || state == RUN)) begin
      state_n = SHIFT_LO;
      div_n = DIV_LD;
      bit_n = BIT_LD;
      sr_n = cfg_word;
    end else if (stop && state != IDLE) begin
      state_n = IDLE;
      div_n = '0;
      bit_n = '0;
    end else if (tick) begin
      case (state)
        SHIFT_LO: begin
          state_n = SHIFT_HI;
          div_n = DIV_LD;
        end
        SHIFT_HI: begin
          div_n = DIV_LD;
          state_n = bit_cnt == '0 ? TAIL : SHIFT_LO;
          bit_n = bit_cnt == '0 ? bit_cnt : bit_cnt - 1'b1;
          sr_n = bit_cnt == '0 ? sr : sr << 1;
        end
        TAIL: begin
          state_n = SETTLE;
          div_n = SET_LD;
        end
        SETTLE: state_n = RUN;
        default: ;
      endcase
    end
  end
  // outputs are registered from the next state so none of them glitch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      div <= '0;
      bit_cnt <= '0;
      sr <= '0;
      cfg_clk <= 1'b0;
      cfg_data <= 1'b0;
      en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      div <= div_n;
      bit_cnt <= bit_n;
      sr <= sr_n;
      cfg_clk <= state_n == SHIFT_HI;
      cfg_data <= (state_n == SHIFT_LO || state_n == SHIFT_HI) && sr_n[CONFIG_LEN-1];
      en <= state_n == RUN;
      busy <= state_n inside {SHIFT_LO, SHIFT_HI, TAIL, SETTLE};
      done <= state_n == RUN && state != RUN;
    end
endmodule

// File: tb/tb_display_cfg_tx.sv
// tb_display_cfg_tx: random and directed checks of two serialisers (CLK_DIV 4 and 2) against a cycle model
module tb_display_cfg_tx;
  import display_cfg_pkg::*;
  localparam int DV[2] = '{4, 2};
  localparam int LAT[2] = '{608, 306};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i[2] = '{1'b0, 1'b0};
  logic stop_i[2] = '{1'b0, 1'b0};
  logic [74:0] word_i[2] = '{75'd0, 75'd0};
  logic cclk[2], cdat[2], en[2], busy[2], done[2];
  int checks = 0, errors = 0;
  int cyc = 0;
  bit m_act[2] = '{1'b0, 1'b0};
  int m_k[2] = '{0, 0};
  int t0[2] = '{0, 0};
  logic [74:0] m_word[2] = '{75'd0, 75'd0};
  logic [74:0] rx[2] = '{75'd0, 75'd0};
  int rx_edges[2] = '{0, 0};
  int stable[2] = '{1000, 1000};
  logic p_clk[2] = '{1'b0, 1'b0};
  logic p_dat[2] = '{1'b0, 1'b0};
  logic p_en[2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  display_cfg_tx #(.CLK_DIV(4), .SETTLE_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .cfg_word(word_i[0]), .start(start_i[0]), .stop(stop_i[0]),
    .cfg_clk(cclk[0]), .cfg_data(cdat[0]), .en(en[0]), .busy(busy[0]), .done(done[0]));
  display_cfg_tx #(.CLK_DIV(2), .SETTLE_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .cfg_word(word_i[1]), .start(start_i[1]), .stop(stop_i[1]),
    .cfg_clk(cclk[1]), .cfg_data(cdat[1]), .en(en[1]), .busy(busy[1]), .done(done[1]));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // {cfg_clk, cfg_data, en, busy, done}, k = edges since the accepted start edge
  function automatic logic [4:0] exp_out(input bit act, input int k, input logic [74:0] w, input int d);
    int lat = 2 * d * 75 + d + 4;
    if (!act) return 5'b00000;
    if (k < 2 * d * 75) return {(k % (2 * d)) >= d, w[74 - k / (2 * d)], 3'b010};
    if (k < lat) return 5'b00010;
    return {4'b0010, k == lat};
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0;
        m_k[i] <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++)
        if (start_i[i] && (!m_act[i] || m_k[i] >= LAT[i])) begin
          m_act[i] <= 1'b1;
          m_k[i] <= 0;
          m_word[i] <= word_i[i];
          t0[i] <= cyc + 1;
        end else if (stop_i[i] && m_act[i]) m_act[i] <= 1'b0;
        else if (m_act[i] && m_k[i] < LAT[i] + 10) m_k[i] <= m_k[i] + 1;
    end

  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("outputs dut%0d", i), 128'({cclk[i], cdat[i], en[i], busy[i], done[i]}),
          128'(exp_out(m_act[i], m_k[i], m_word[i], DV[i])));
      if (m_act[i] && m_k[i] == 0) rx_edges[i] <= 0;
      if (cclk[i] === 1'b1 && p_clk[i] === 1'b0) begin
        chk($sformatf("setup dut%0d", i), 128'(cdat[i] == p_dat[i] && stable[i] >= DV[i] - 1), 128'(1));
        rx[i] <= {rx[i][73:0], cdat[i]};
        rx_edges[i] <= rx_edges[i] + 1;
      end
      stable[i] <= (cdat[i] !== p_dat[i]) ? 0 : stable[i] + 1;
      if (en[i] === 1'b1 && p_en[i] === 1'b0) begin
        chk($sformatf("latency dut%0d", i), 128'(cyc - t0[i]), 128'(LAT[i]));
        chk($sformatf("captured dut%0d", i), 128'(rx[i]), 128'(m_word[i]));
        chk($sformatf("edges dut%0d", i), 128'(rx_edges[i]), 128'(75));
      end
      p_clk[i] <= cclk[i];
      p_dat[i] <= cdat[i];
      p_en[i] <= en[i];
    end

  task automatic drive(input int i, input bit s, input bit p, input logic [74:0] w);
    @(negedge clk);
    start_i[i] = s;
    stop_i[i] = p;
    if (s) word_i[i] = w;
    @(negedge clk);
    start_i[i] = 1'b0;
    stop_i[i] = 1'b0;
  endtask

  task automatic wait_en(input int i);
    int c = 0;
    while (en[i] !== 1'b1 && c < 800) begin
      @(negedge clk);
      c++;
    end
    chk($sformatf("en_timeout dut%0d", i), 128'(en[i]), 128'(1));
  endtask

  function automatic logic [74:0] rnd_word();
    return 75'({$urandom(), $urandom(), $urandom()});
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [74:0] wa, wb;
    bit seen;
    int c;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset outs", 128'({cclk[0], cdat[0], en[0], busy[0], done[0]}), 128'(0));
    // 640x480 load
    wa = {6'd8, 1'b1, 1'b1, 11'd639, 9'd15, 9'd95, 9'd47, 11'd479, 6'd9, 6'd1, 6'd32};
    drive(0, 1, 0, wa);
    chk("busy after start", 128'({en[0], busy[0]}), 128'(2'b01));
    wait_en(0);
    chk("done pulse", 128'(done[0]), 128'(1));
    chk("pulse_count", 128'(rx[0][PULSE_COUNT_MSB:PULSE_COUNT_LSB]), 128'(8));
    chk("h_pol", 128'(rx[0][H_POL]), 128'(1));
    chk("h_display", 128'(rx[0][H_DISPLAY_MSB:H_DISPLAY_LSB]), 128'(639));
    chk("h_sync", 128'(rx[0][H_SYNC_MSB:H_SYNC_LSB]), 128'(95));
    chk("v_display", 128'(rx[0][V_DISPLAY_MSB:V_DISPLAY_LSB]), 128'(479));
    chk("v_top", 128'(rx[0][V_TOP_MSB:V_TOP_LSB]), 128'(32));
    @(negedge clk);
    chk("done once", 128'({en[0], done[0]}), 128'(2'b10));
    // alternating pattern on the fast divider
    wb = {1'b0, {37{2'b10}}};
    drive(1, 1, 0, wb);
    wait_en(1);
    chk("alt word", 128'(rx[1]), 128'(wb));
    // restart from RUN, with a second start ignored around bit 30
    wa = rnd_word();
    drive(0, 1, 0, wa);
    chk("restart en low", 128'({en[0], busy[0]}), 128'(2'b01));
    repeat (238) @(negedge clk);
    drive(0, 1, 0, ~wa);
    wait_en(0);
    chk("busy ignore word", 128'(rx[0]), 128'(wa));
    // start and stop together from RUN reloads
    wa = rnd_word();
    drive(0, 1, 1, wa);
    chk("start+stop reload", 128'({en[0], busy[0]}), 128'(2'b01));
    wait_en(0);
    // stop in RUN
    drive(0, 0, 1, 75'd0);
    chk("stop en low", 128'({en[0], busy[0]}), 128'(2'b00));
    // abort during bit 10
    drive(0, 1, 0, {75{1'b1}});
    repeat (80) @(negedge clk);
    drive(0, 0, 1, 75'd0);
    chk("abort outs", 128'({cclk[0], cdat[0], en[0], busy[0]}), 128'(0));
    seen = 1'b0;
    repeat (700) begin
      @(negedge clk);
      seen |= done[0] | en[0] | cclk[0];
    end
    chk("abort quiet", 128'(seen), 128'(0));
    // async reset mid SHIFT_HI
    drive(0, 1, 0, rnd_word());
    c = 0;
    while (cclk[0] !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("reached shift_hi", 128'(cclk[0]), 128'(1));
    #2 rst = 1'b1;
    #1 chk("async reset", 128'({cclk[0], cdat[0], en[0], busy[0], done[0]}), 128'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen |= cclk[0] | busy[0] | en[0];
    end
    chk("idle after reset", 128'(seen), 128'(0));
    // randomized traffic on both instances
    for (int n = 0; n < 24; n++) begin
      int i = int'($urandom_range(0, 1));
      int a = int'($urandom_range(0, 3));
      drive(i, a != 2, a >= 2, rnd_word());
      repeat ($urandom_range(1, LAT[i] + 50)) @(negedge clk);
    end
    repeat (700) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_cfg_tx.md
Name: display_cfg_tx

Overview:
- Transmit end of the display timing generator's serial config interface: serialises a packed CONFIG_LEN-bit timing word onto cfg_clk/cfg_data, then raises en to start the display.
- Sits between the frame controller/register file and the timing generator.
- Guarantees en is low for the whole shift, and that the receiver's 3-stage cfg_clk synchroniser has consumed the last edge before en rises.

Parameters:
- CONFIG_LEN, 75, serial word length (pulse_count 6, h_pol, v_pol, h_display 11, h_front/h_sync/h_back 9 each, v_display 11, v_bottom/v_sync/v_top 6 each).
- CLK_DIV, 4, clk cycles per cfg_clk half-period; must be >= 2.
- SETTLE_CYCLES, 4, clk cycles between the final cfg_clk low and en rising; must be >= 4.

Ports:
- clk  in  1  system clock, same domain as the timing generator.
- rst  in  1  asynchronous active-high reset.
- cfg_word  in  CONFIG_LEN  packed config; bit CONFIG_LEN-1 is pulse_count MSB, bit 0 is v_top LSB; sampled only on an accepted start.
- start  in  1  single-cycle request to (re)configure and enable.
- stop  in  1  single-cycle request to disable the display (en low).
- cfg_clk  out  1  serial config clock to the timing generator.
- cfg_data  out  1  serial config data, MSB first.
- en  out  1  display enable to the timing generator.
- busy  out  1  high from the accepted start until en rises.
- done  out  1  one-cycle pulse on the first cycle en is high.

Behaviour:
- Reset: async, immediate. State IDLE; cfg_clk=0, cfg_data=0, en=0, busy=0, done=0; counters and shift register cleared.
- All outputs are registered, with no combinational path from inputs.
- States:
  - IDLE (en=0)
  - SHIFT_LO (cfg_clk=0, cfg_data=current bit)
  - SHIFT_HI (cfg_clk=1, cfg_data held)
  - TAIL (cfg_clk=0, cfg_data=0)
  - SETTLE (cfg_clk=0, cfg_data=0)
  - RUN (en=1)
- start accepted in IDLE or RUN:
  - latch cfg_word into shift register;
  - bit counter = CONFIG_LEN-1, divider = CLK_DIV-1;
  - enter SHIFT_LO; en=0 and busy=1 from the next cycle.
- start in SHIFT_LO/SHIFT_HI/TAIL/SETTLE is ignored; cfg_word changes there have no effect.
- SHIFT_LO:
  - cfg_data = shift register MSB for the whole phase.
  - After CLK_DIV cycles, go to SHIFT_HI.
- SHIFT_HI:
  - After CLK_DIV cycles: if bit counter == 0, go to TAIL; else shift left by one, decrement the counter, go to SHIFT_LO.
- cfg_data changes only on entry to SHIFT_LO, so it is stable for a full half-period either side of each cfg_clk rising edge.
- Exactly CONFIG_LEN cfg_clk rising edges per configuration.
- TAIL lasts CLK_DIV cycles.
- SETTLE lasts SETTLE_CYCLES cycles, then go to RUN: en=1, busy=0, done=1 for one cycle.
- Latency: start sampled at edge N → en first high after edge N + 2*CLK_DIV*CONFIG_LEN + CLK_DIV + SETTLE_CYCLES. Defaults give 608 cycles.
- stop:
  - In RUN → IDLE, en low the next cycle.
  - In IDLE: no effect.
  - During shifting: aborts to IDLE with cfg_clk=0 and cfg_data=0; the receiver holds a partial word, which is harmless because en stays low.
- Simultaneous start and stop: start wins (restart sequence).
- Restart from RUN: en drops the cycle after start, and the display resets to its back-porch state per timing-generator semantics.
- Divider and bit counter widths: $clog2 of CLK_DIV, SETTLE_CYCLES and CONFIG_LEN; no wrap is possible within legal parameters.

Decomposition:
- Shared package display_cfg_pkg holds:
  - CONFIG_LEN;
  - field MSB/LSB localparams (PULSE_COUNT 74:69, H_POL 68, V_POL 67, H_DISPLAY 66:56, H_FRONT 55:47, H_SYNC 46:38, H_BACK 37:29, V_DISPLAY 28:18, V_BOTTOM 17:12, V_SYNC 11:6, V_TOP 5:0);
  - state encodings.
- Timing fields hold count-1 (a value of 639 gives 640 pixels). The packer outside this block owns that convention.
- No sub-module. The divider and bit counter stay inline (est. 150 lines).

Test Plan:
- Reset/idle:
  - Stimulus: assert rst mid-SHIFT_HI, then deassert.
  - Required: cfg_clk, cfg_data, en, busy, done all 0 immediately and held; no cfg_clk edges until start.
- 640x480 load:
  - Stimulus: cfg_word with pulse_count=8, h_pol=1, v_pol=1, h_display=639, h_front=15, h_sync=95, h_back=47, v_display=479, v_bottom=9, v_sync=1, v_top=32; start.
  - Required: a receiver model sampling cfg_data on cfg_clk rising edges captures the same 75-bit word; exactly 75 rising edges; en rises 608 cycles after start; done pulses once.
- Data stability:
  - Stimulus: CLK_DIV=2 with alternating word 0x2AAA…A.
  - Required: cfg_data never toggles within 2 cycles of any cfg_clk rising edge; captured word matches.
- Busy ignore:
  - Stimulus: second start with a different cfg_word at bit 30.
  - Required: the original word is captured; en timing is unchanged.
- Restart and stop:
  - Stimulus: start while RUN.
  - Required: en low the next cycle, then a full 608-cycle reload.
  - Stimulus: stop in RUN.
  - Required: en low the next cycle.
  - Stimulus: start and stop in the same cycle.
  - Required: reload occurs.
- Abort:
  - Stimulus: stop during bit 10.
  - Required: IDLE; cfg_clk=0, en=0, busy=0; no done pulse.
